ingress_voq: RTL and testbench

- Per-ingress-port virtual output queue (VOQ) block for the 4x4 crossbar switch.
- Accepts packets from the ingress MAC side and buffers them in four per-egress FIFOs (VOQ 0..3).
- Reports queue and busy status to the scheduler, and answers its grants by streaming one packet per grant into the crossbar.
- One instance per ingress port; it is the responder side of the scheduler's sched_sel_en/sched_sel interface.

---
 rtl/ingress_voq.sv | 180 ++++++++++++++++++
 tb/tb_ingress_voq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_voq.sv
`default_nettype none
// ============================================================================
//  Module   : ingress_voq
//  Purpose  : Per-ingress-port virtual output queue block for a 4x4 crossbar.
//             Buffers incoming packets into four per-egress FIFOs (VOQ 0..3),
//             reports queue/busy status to the scheduler and streams one
//             packet into the crossbar for every scheduler grant.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             in_valid/in_ready     - ingress word handshake
//             in_data/in_sop/in_eop - ingress word and packet framing
//             in_dest               - egress of the packet (sop word only)
//             voq_empty             - per-VOQ "no complete packet" flags
//             is_busy/busy_voq_num  - transfer in progress / source VOQ
//             sched_sel_en/sched_sel- scheduler grant level and VOQ select
//             out_valid/out_data/out_eop/out_voq - crossbar word stream
//             grant_err             - one-cycle pulse on an invalid grant
//  Revision : 1.0 - initial release
// ============================================================================
module ingress_voq #(
  parameter int DATA_W    = 32,
  parameter int VOQ_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [1:0]        in_dest,
  output logic [3:0]        voq_empty,
  output logic              is_busy,
  output logic [1:0]        busy_voq_num,
  input  logic              sched_sel_en,
  input  logic [1:0]        sched_sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eop,
  output logic [1:0]        out_voq,
  output logic              grant_err
);

  localparam int AW = $clog2(VOQ_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      busy_q, busy_d;
  logic            err_q, err_d;
  logic            sel_en_q;
  logic [1:0]      cur_dest_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]     wr_ptr_q  [0:3];
  logic [AW:0]     rd_ptr_q  [0:3];
  logic [AW:0]     pkt_cnt_q [0:3];
  logic [DATA_W:0] mem_q     [0:3][0:VOQ_DEPTH-1];

  logic [3:0]      full;
  logic [3:0]      push_v, pop_v, inc_v, dec_v;
  logic [1:0]      tgt;
  logic            wr_en;
  logic            grant;
  logic            sending;
  logic [DATA_W:0] rd_word;
  logic            rd_eop;

  // Non-sop words follow the destination latched from their sop word.
  assign tgt   = in_sop ? in_dest : cur_dest_q;
  assign in_ready = !full[tgt];
  assign wr_en = in_valid && in_ready;
  assign grant = sched_sel_en && !sel_en_q;

  assign sending = (state_q == S_SEND);
  assign rd_word = mem_q[busy_q][rd_ptr_q[busy_q][AW-1:0]];
  assign rd_eop  = sending && rd_word[DATA_W];

  // The head word of the granted VOQ is presented directly while sending, so
  // the first word appears in the cycle right after the grant edge and the
  // output drops together with the state register on reset.
  assign out_valid    = sending;
  assign out_data     = sending ? rd_word[DATA_W-1:0] : '0;
  assign out_eop      = rd_eop;
  assign out_voq      = busy_q;
  assign is_busy      = sending;
  assign busy_voq_num = busy_q;
  assign grant_err    = err_q;

  always_comb begin
    full      = '0;
    voq_empty = '0;
    push_v    = '0;
    pop_v     = '0;
    inc_v     = '0;
    dec_v     = '0;
    for (int v = 0; v < 4; v++) begin
      full[v]      = (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]) &&
                     (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]);
      voq_empty[v] = (pkt_cnt_q[v] == '0);
      push_v[v]    = wr_en && (tgt == v[1:0]);
      pop_v[v]     = sending && (busy_q == v[1:0]);
      inc_v[v]     = push_v[v] && in_eop;
      dec_v[v]     = pop_v[v] && rd_eop;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          if (pkt_cnt_q[sched_sel] != '0) begin
            state_d = S_SEND;
            busy_d  = sched_sel;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        // Re-granting the VOQ already being sent is harmless and ignored.
        if (grant && (sched_sel != busy_q)) begin
          err_d = 1'b1;
        end
        if (rd_eop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 2'd0;
      err_q      <= 1'b0;
      sel_en_q   <= 1'b0;
      cur_dest_q <= 2'd0;
      for (int v = 0; v < 4; v++) begin
        wr_ptr_q[v]  <= '0;
        rd_ptr_q[v]  <= '0;
        pkt_cnt_q[v] <= '0;
      end
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      sel_en_q <= sched_sel_en;
      if (wr_en && in_sop) begin
        cur_dest_q <= in_dest;
      end
      for (int v = 0; v < 4; v++) begin
        if (push_v[v]) begin
          wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
        end
        if (pop_v[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
        end
        // Enqueue eop and dequeue eop in the same cycle cancel out.
        pkt_cnt_q[v] <= pkt_cnt_q[v] + {{AW{1'b0}}, inc_v[v]}
                                     - {{AW{1'b0}}, dec_v[v]};
      end
    end
  end

  // Packet storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tgt][wr_ptr_q[tgt][AW-1:0]] <= {in_eop, in_data};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ingress_voq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ingress_voq
//  Purpose  : Self-checking bench for ingress_voq. A queue-of-words model of
//             the four VOQs and the one-packet-per-grant transfer rule is
//             stepped once per clock and compared against the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ingress_voq;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic [1:0]        in_dest = 2'd0;
  logic [3:0]        voq_empty;
  logic              is_busy;
  logic [1:0]        busy_voq_num;
  logic              sched_sel_en = 1'b0;
  logic [1:0]        sched_sel = 2'd0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_eop;
  logic [1:0]        out_voq;
  logic              grant_err;

  ingress_voq #(.DATA_W(DATA_W), .VOQ_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_dest      (in_dest),
    .voq_empty    (voq_empty),
    .is_busy      (is_busy),
    .busy_voq_num (busy_voq_num),
    .sched_sel_en (sched_sel_en),
    .sched_sel    (sched_sel),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_eop      (out_eop),
    .out_voq      (out_voq),
    .grant_err    (grant_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: each VOQ is a FIFO of {eop, data}; a VOQ holds a
  // complete packet exactly when some queued word carries eop.
  logic [DATA_W:0] mq [4][$];
  bit              m_busy;
  logic [1:0]      m_voq;
  bit              m_err;
  bit              m_prev;
  logic [1:0]      m_cur;
  bit              m_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_pkt(input int v);
    for (int i = 0; i < mq[v].size(); i++) begin
      if (mq[v][i][DATA_W]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 4; v++) mq[v].delete();
    m_busy = 0; m_voq = 2'd0; m_err = 0; m_prev = 0; m_cur = 2'd0; m_acc = 0;
  endtask

  // Check the current cycle against the model, advance the model by the
  // clock edge that follows, then return just after that edge.
  task automatic cycle();
    logic [1:0]      tgt;
    logic [3:0]      emp;
    logic [DATA_W:0] w;
    bit              rdy, grant, hp;
    #1;
    tgt = in_sop ? in_dest : m_cur;
    rdy = mq[tgt].size() < DEPTH;
    for (int v = 0; v < 4; v++) emp[v] = !has_pkt(v);
    chk("in_ready", in_ready, rdy);
    chk("voq_empty", voq_empty, emp);
    chk("is_busy", is_busy, m_busy);
    chk("out_valid", out_valid, m_busy);
    chk("grant_err", grant_err, m_err);
    if (m_busy) begin
      w = mq[m_voq][0];
      chk("out_data", out_data, w[DATA_W-1:0]);
      chk("out_eop", out_eop, w[DATA_W]);
      chk("out_voq", out_voq, m_voq);
      chk("busy_voq_num", busy_voq_num, m_voq);
    end
    grant = sched_sel_en && !m_prev;
    hp    = has_pkt(sched_sel);
    m_acc = in_valid && rdy;
    m_err = 0;
    if (m_busy) begin
      if (grant && sched_sel != m_voq) m_err = 1;
      w = mq[m_voq].pop_front();
      if (w[DATA_W]) m_busy = 0;
    end else if (grant) begin
      if (hp) begin
        m_busy = 1;
        m_voq  = sched_sel;
      end else begin
        m_err = 1;
      end
    end
    if (m_acc) begin
      mq[tgt].push_back({in_eop, in_data});
      if (in_sop) m_cur = in_dest;
    end
    m_prev = sched_sel_en;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_pkt(input logic [1:0] dest, input int len, input logic [DATA_W-1:0] base);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == len - 1);
      in_dest  = dest;
      in_data  = base + DATA_W'(i);
      cycle();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rem;
    bit         first;
    logic [1:0] rdest;

    // ---------------- reset values ----------------
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_voq_empty", voq_empty, 4'b1111);
    chk("rst_is_busy", is_busy, 1'b0);
    chk("rst_busy_voq", busy_voq_num, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_eop", out_eop, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_voq", out_voq, 2'd0);
    chk("rst_grant_err", grant_err, 1'b0);
    rst_n = 1'b1;
    run(2);

    // ---------------- 3-word packet to VOQ 2, then grant ----------------
    send_pkt(2'd2, 3, 32'hA0);
    chk("empty_after_pkt2", voq_empty, 4'b1011);
    sched_sel = 2'd2; sched_sel_en = 1'b1;
    cycle();                               // grant cycle N
    sched_sel_en = 1'b0;
    chk("first_word_valid", out_valid, 1'b1);
    chk("first_word_data", out_data, 32'hA0);
    chk("first_word_voq", out_voq, 2'd2);
    run(3);                                // N+1..N+3
    chk("empty_after_send2", voq_empty, 4'b1111);
    chk("idle_after_send2", is_busy, 1'b0);

    // ---------------- held grant level sends only one packet ----------------
    send_pkt(2'd0, 2, 32'h100);
    send_pkt(2'd0, 3, 32'h200);
    sched_sel = 2'd0; sched_sel_en = 1'b1;
    run(10);
    sched_sel_en = 1'b0;
    cycle();
    chk("held_level_voq0_pending", voq_empty[0], 1'b0);

    // ---------------- grant on empty VOQ 1 ----------------
    sched_sel = 2'd1; sched_sel_en = 1'b1;
    cycle();
    sched_sel_en = 1'b0;
    chk("empty_grant_err", grant_err, 1'b1);
    chk("empty_grant_no_out", out_valid, 1'b0);
    cycle();
    chk("empty_grant_err_pulse", grant_err, 1'b0);

    // ---------------- foreign grant during VOQ 0 transfer ----------------
    send_pkt(2'd0, 2, 32'h250);            // VOQ 0 now holds two packets
    sched_sel = 2'd0; sched_sel_en = 1'b1;
    cycle();
    sched_sel_en = 1'b0;
    cycle();
    sched_sel = 2'd3; sched_sel_en = 1'b1;
    cycle();
    sched_sel_en = 1'b0;
    chk("foreign_grant_err", grant_err, 1'b1);
    chk("foreign_grant_busy", is_busy, 1'b1);
    run(4);

    // ---------------- fill VOQ 1 with a 64-word partial packet ----------------
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0;
      in_dest = 2'd1; in_data = 32'h1000 + i;
      cycle();
    end
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_dest = 2'd1; in_data = 32'hDEAD;
    #1;
    chk("full_voq1_ready", in_ready, 1'b0);
    cycle();
    in_dest = 2'd0; in_data = 32'h5A5A;
    #1;
    chk("voq0_ready_while_voq1_full", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    cycle();
    chk("voq1_partial_still_empty", voq_empty, 4'b1110);

    // ---------------- reset during a 4-word transfer ----------------
    send_pkt(2'd3, 4, 32'h300);
    sched_sel = 2'd3; sched_sel_en = 1'b1;
    cycle();
    sched_sel_en = 1'b0;
    cycle();                               // word 1 shown; word 2 shown next
    #2;
    chk("pre_reset_word2", out_data, 32'h301);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_is_busy", is_busy, 1'b0);
    chk("mid_rst_voq_empty", voq_empty, 4'b1111);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(2);
    send_pkt(2'd1, 2, 32'h400);
    sched_sel = 2'd1; sched_sel_en = 1'b1;
    cycle();
    sched_sel_en = 1'b0;
    chk("post_rst_word", out_data, 32'h400);
    run(4);

    // ---------------- randomized traffic and grants ----------------
    rem = 0; first = 0; rdest = 2'd0;
    for (int c = 0; c < 1500; c++) begin
      if (rem == 0 && $urandom_range(0, 3) != 0) begin
        rem   = $urandom_range(1, 6);
        rdest = 2'($urandom_range(0, 3));
        first = 1;
      end
      in_valid = (rem != 0) && ($urandom_range(0, 4) != 0);
      in_sop   = first;
      in_eop   = (rem == 1);
      in_dest  = first ? rdest : 2'($urandom);
      in_data  = $urandom;
      if ($urandom_range(0, 2) == 0) sched_sel_en = ~sched_sel_en;
      sched_sel = 2'($urandom);
      cycle();
      if (m_acc) begin
        rem--;
        first = 0;
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; sched_sel_en = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
